// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants for the BCD countdown timer: control state codes, per-digit limits
// and the digit saturation helper used when loading a set value.
package bcd_countdown_timer_pkg;

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_SET   = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_START = 4'd3;
  localparam logic [3:0] ST_IDLE  = 4'd4;

  // Digit index 0 is S0 (least significant), index 5 is H1.
  localparam logic [3:0] MAX_S0 = 4'd9;
  localparam logic [3:0] MAX_S1 = 4'd5;
  localparam logic [3:0] MAX_M0 = 4'd9;
  localparam logic [3:0] MAX_M1 = 4'd5;
  localparam logic [3:0] MAX_H0 = 4'd9;
  localparam logic [3:0] MAX_H1 = 4'd1;

  // Value forced in when a start finds more than 12 hours loaded.
  localparam logic [23:0] HOURS_CLAMP = 24'h12_59_59;

  function automatic logic [3:0] sat_digit(input logic [3:0] val, input logic [3:0] maxVal);
    return (val > maxVal) ? maxVal : val;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD down-counting digit with clear, load and borrow output; six are chained
// least-significant first to form the hh:mm:ss countdown register.
module bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ldVal,
  input  logic       dec,
  output logic [3:0] q,
  output logic       isZero,
  output logic       borrowOut
);

  assign isZero    = (q == 4'd0);
  assign borrowOut = dec && isZero;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (load) begin
      q <= ldVal;
    end else if (dec) begin
      q <= isZero ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Medication countdown: loads a clamped BCD hh:mm:ss value, counts down once per second
// while running and raises a sticky expired flag on reaching 00:00:00.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESC_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic [23:0] timeSetBits,
  output logic [23:0] timeDigits,
  output logic        running,
  output logic        expired,
  output logic        secondPulse
);

  localparam logic [3:0] DIGIT_MAX [6] = '{MAX_S0, MAX_S1, MAX_M0, MAX_M1, MAX_H0, MAX_H1};

  logic [PRESC_W-1:0] presc;
  logic [3:0]         digitQ    [6];
  logic [5:0]         zeroVec;
  logic [5:0]         borrowVec;
  logic [5:0]         decVec;
  logic [23:0]        ldVal;

  logic softClr, doSet, tick, doDec, doStart, doClamp, doLoad;
  logic allZero, isOne, hoursOver;

  assign softClr   = (state == ST_RESET);
  assign doSet     = (state == ST_SET);
  assign tick      = running && (presc == PRESC_W'(TICKS_PER_SEC - 1));
  assign doDec     = tick && !softClr && !doSet;
  assign allZero   = &zeroVec;
  assign isOne     = (&zeroVec[5:1]) && (digitQ[0] == 4'd1);
  assign hoursOver = timeDigits[23:16] > 8'h12;
  // A start only acts while stopped; a nonzero value over 12 h is clamped as it starts.
  assign doStart   = (state == ST_START) && !softClr && !doSet && !running;
  assign doClamp   = doStart && !allZero && hoursOver;
  assign doLoad    = doSet || doClamp;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ldVal = HOURS_CLAMP;
    if (doSet) begin
      for (int i = 0; i < 6; i++) begin
        ldVal[i*4 +: 4] = sat_digit(timeSetBits[i*4 +: 4], DIGIT_MAX[i]);
      end
    end
  end

  assign decVec = {borrowVec[4:0], doDec};

  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_digit_down #(.MAX(DIGIT_MAX[i])) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (softClr),
      .load     (doLoad),
      .ldVal    (ldVal[i*4 +: 4]),
      .dec      (decVec[i]),
      .q        (digitQ[i]),
      .isZero   (zeroVec[i]),
      .borrowOut(borrowVec[i])
    );
    assign timeDigits[i*4 +: 4] = digitQ[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      running     <= 1'b0;
      expired     <= 1'b0;
      secondPulse <= 1'b0;
    end else if (softClr || doSet) begin
      presc       <= '0;
      running     <= 1'b0;
      expired     <= 1'b0;
      secondPulse <= 1'b0;
    end else begin
      secondPulse <= doDec;
      if (doDec) begin
        presc <= '0;
        if (isOne) begin
          running <= 1'b0;
          expired <= 1'b1;
        end
      end else if (running) begin
        presc <= presc + 1'b1;
      end else if (doStart) begin
        if (allZero) expired <= 1'b1;
        else         running <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized and directed bench for bcd_countdown_timer, checked against a reference model
// that tracks the remaining time as a plain count of seconds.
module tb_bcd_countdown_timer;

  localparam int TPS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  state = 4'd0;
  logic [23:0] timeSetBits = 24'h0;
  logic [23:0] timeDigits;
  logic        running, expired, secondPulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mSecs = 0;
  int mCnt = 0;
  bit mRun = 0, mExp = 0, mPulse = 0;
  int pulseCount = 0;

  bcd_countdown_timer #(.TICKS_PER_SEC(TPS), .PRESC_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .timeSetBits(timeSetBits),
    .timeDigits (timeDigits),
    .running    (running),
    .expired    (expired),
    .secondPulse(secondPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Set value after per-digit saturation, in seconds.
  function automatic int set_to_secs(input logic [23:0] v);
    int d[6];
    int lim[6] = '{9, 5, 9, 5, 9, 1};
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > lim[i]) d[i] = lim[i];
    end
    return (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
  endfunction

  task automatic model_step(input logic [3:0] st, input logic [23:0] sv);
    mPulse = 0;
    if (st == 4'd0) begin
      mSecs = 0; mRun = 0; mExp = 0; mCnt = 0;
    end else if (st == 4'd1) begin
      mSecs = set_to_secs(sv); mRun = 0; mExp = 0; mCnt = 0;
    end else if (mRun && mCnt == TPS - 1) begin
      mCnt = 0; mSecs--; mPulse = 1;
      if (mSecs == 0) begin mExp = 1; mRun = 0; end
    end else if (mRun) begin
      mCnt++;
    end else if (st == 4'd3) begin
      if (mSecs == 0) mExp = 1;
      else begin
        if (mSecs / 3600 > 12) mSecs = 12 * 3600 + 59 * 60 + 59;
        mRun = 1;
      end
    end
  endtask

  task automatic model_reset();
    mSecs = 0; mRun = 0; mExp = 0; mCnt = 0; mPulse = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".digits"}, 32'(timeDigits), 32'(to_bcd(mSecs)));
    check({tag, ".running"}, 32'(running), 32'(mRun));
    check({tag, ".expired"}, 32'(expired), 32'(mExp));
    check({tag, ".pulse"}, 32'(secondPulse), 32'(mPulse));
  endtask

  // Inputs change 1 time unit after an edge; outputs are compared right after.
  task automatic cycle(input logic [3:0] st, input logic [23:0] sv, input string tag);
    state = st;
    timeSetBits = sv;
    @(posedge clk);
    model_step(st, sv);
    #1;
    if (mPulse) pulseCount++;
    compare_all(tag);
  endtask

  initial begin
    int r;
    logic [3:0] st;
    logic [23:0] sv;

    #2;
    check("reset.digits", 32'(timeDigits), 32'h0);
    check("reset.running", 32'(running), 32'h0);
    check("reset.expired", 32'(expired), 32'h0);
    check("reset.pulse", 32'(secondPulse), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Five-second countdown to expiry
    cycle(4'd1, 24'h000005, "set5");
    cycle(4'd3, 24'h0, "start5");
    pulseCount = 0;
    for (int i = 0; i < 20; i++) cycle(4'd4, 24'h0, "run5");
    check("run5.final_digits", 32'(timeDigits), 32'h0);
    check("run5.final_expired", 32'(expired), 32'h1);
    check("run5.final_running", 32'(running), 32'h0);
    check("run5.pulses", 32'(pulseCount), 32'd5);
    for (int i = 0; i < 6; i++) cycle(4'd4, 24'h0, "hold0");

    // Borrow chains across minutes and hours
    cycle(4'd1, 24'h010000, "set1h");
    cycle(4'd3, 24'h0, "start1h");
    for (int i = 0; i < TPS; i++) cycle(4'd4, 24'h0, "tick1h");
    check("borrow_1h", 32'(timeDigits), 32'h005959);
    cycle(4'd1, 24'h100000, "set10h");
    cycle(4'd3, 24'h0, "start10h");
    for (int i = 0; i < TPS; i++) cycle(4'd4, 24'h0, "tick10h");
    check("borrow_10h", 32'(timeDigits), 32'h095959);

    // Start with zero loaded
    cycle(4'd1, 24'h000000, "set0");
    cycle(4'd3, 24'h0, "start0");
    check("start0.expired", 32'(expired), 32'h1);
    check("start0.running", 32'(running), 32'h0);
    check("start0.pulse", 32'(secondPulse), 32'h0);

    // Reload while running, and undefined codes hold
    cycle(4'd1, 24'h000030, "set30");
    cycle(4'd3, 24'h0, "start30");
    for (int i = 0; i < 10; i++) cycle(4'd7, 24'h0, "code7");
    check("code7.running", 32'(running), 32'h1);
    check("code7.digits", 32'(timeDigits), 32'h000028);
    cycle(4'd1, 24'h000010, "reload");
    check("reload.running", 32'(running), 32'h0);
    check("reload.expired", 32'(expired), 32'h0);
    check("reload.digits", 32'(timeDigits), 32'h000010);

    // Per-digit saturation, then hours clamp on start
    cycle(4'd1, 24'h1F6FAF, "sat");
    check("sat.digits", 32'(timeDigits), 32'h195959);
    cycle(4'd3, 24'h0, "clamp");
    check("clamp.digits", 32'(timeDigits), 32'h125959);
    check("clamp.running", 32'(running), 32'h1);

    // Asynchronous reset mid-count at 00:00:03
    cycle(4'd1, 24'h000005, "setar");
    cycle(4'd3, 24'h0, "startar");
    for (int i = 0; i < 2 * TPS; i++) cycle(4'd4, 24'h0, "runar");
    check("async.pre", 32'(timeDigits), 32'h000003);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async.digits", 32'(timeDigits), 32'h0);
    check("async.running", 32'(running), 32'h0);
    check("async.expired", 32'(expired), 32'h0);
    check("async.pulse", 32'(secondPulse), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: mostly idle so countdowns make progress
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       st = 4'd0;
      else if (r < 6)  st = 4'd1;
      else if (r < 12) st = 4'd3;
      else if (r < 16) st = 4'(2 + $urandom_range(0, 13));
      else             st = 4'd4;
      sv = 24'($urandom);
      if ($urandom_range(0, 3) != 0) sv = {16'h0, sv[7:0]};
      cycle(st, sv, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
